pulse2level: RTL
================

# pulse2level

Reconstructs a held level from single-cycle edge pulses (`rise`, `fall`, `double`), the inverse of the level-to-pulse edge detector. It enforces a programmable minimum hold time on the output level. Events that arrive during the hold window are queued one deep, and any overwritten event is flagged. It sits on the receiving side of a pulse-encoded control path and regenerates the level that the upstream edge detector encoded.

## Interface
- `MIN_HOLD`, default 4: minimum number of cycles `level` stays stable after a change; legal range is ≥1.
- `CNT_W`, default 8: hold counter width; requires `MIN_HOLD-1 < 2**CNT_W`.
- `INIT_LEVEL`, default 1'b0: value of `level` after reset.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `rise`  in  1  one-cycle pulse requesting level = 1.
- `fall`  in  1  one-cycle pulse requesting level = 0.
- `double`  in  1  one-cycle pulse requesting a toggle.
- `level`  out  1  reconstructed level, registered.
- `busy`  out  1  hold window active; a level change is not allowed this cycle.
- `pending`  out  1  one queued event is waiting for the hold to expire.
- `drop`  out  1  one-cycle pulse: a queued event was overwritten or cancelled.

## Operation
- **Event decode, per cycle.** `base` = pending target if `pending`=1, else `level`.
  - `double`, or `rise` & `fall` together → target = ~`base`.
  - Otherwise `rise` → target 1; `fall` → target 0.
  - No pulse → no event.
- **Idle** (`busy`=0, `pending`=0), event with target ≠ `level`: `level` ← target and the hold counter loads `MIN_HOLD-1`.
- **Idle**, event with target = `level`: no-op. No hold reload, no flags.
- **Busy** (hold counter ≠ 0), event present: the pending register stores the target and `pending` goes to 1.
  - If `pending` was already 1, the new target replaces it and `drop` pulses.
- **Hold expired** (counter = 0) with `pending`=1: the applied target = decode(new event, `base`=pending target), or the pending target if no event arrives.
  - `pending` clears.
  - If the applied target ≠ `level`: `level` changes and the counter reloads.
  - If an event is present this cycle, `drop` pulses because the queued event was superseded.
- **Counter.** Decrements by 1 each cycle while nonzero and saturates at 0. `busy` = (counter ≠ 0).
- **`MIN_HOLD`=1.** The counter is always loaded with 0, so `busy` and `pending` stay 0 permanently. The block behaves as a pure pulse-to-level converter.
- **Reset.** `rst`=1 forces:
  - `level`=`INIT_LEVEL`;
  - counter=0, `busy`=0;
  - `pending`=0, pending target=0;
  - `drop`=0.
  - Input pulses in reset cycles are ignored. Reset mid-hold or with an event pending discards all state.

## Timing
- All outputs are registered. There are no combinational paths from inputs to outputs.
- **Latency.** An accepted event in cycle N changes `level` in cycle N+1.
- **Hold guarantee.** After a change visible in cycle N+1, `level` cannot change again before cycle N+1+`MIN_HOLD`.
  - `busy`=1 in cycles N+1 … N+`MIN_HOLD`-1.
  - `busy`=0 in cycle N+`MIN_HOLD`.
- **Queued event.** An event captured in cycle M makes `pending`=1 from cycle M+1. It is applied on the edge ending the first cycle with `busy`=0, so `level` and `pending`=0 update one cycle later.
- **`drop`.** High for exactly the one cycle after the overwrite or supersede edge.
- **Simultaneous events.** Reset wins over any input. A toggle (`double`, or `rise`+`fall`) takes priority over a single `rise` or `fall`.

## Test plan
All scenarios use `MIN_HOLD`=4 and `INIT_LEVEL`=0 unless stated.
1. **Reset with input active.** `rst`=1 for 2 cycles with `rise`=1 held → `level`=0, `busy`=0, `pending`=0, `drop`=0 throughout. First `rise` after release (cycle 0) → `level`=1 from cycle 1.
2. **Single event and hold window.** `rise` at cycle 0 → `level`=1 cycles 1+; `busy`=1 cycles 1–3, `busy`=0 cycle 4. `fall` at cycle 4 → `level`=0 at cycle 5.
3. **Queued event.** `rise` at cycle 0, `fall` at cycle 2 → `pending`=1 cycles 3–4; `level`=0 at cycle 5; `busy`=1 cycles 5–7.
4. **Overwrite then superseded pending.** `rise` at cycle 0, `fall` at cycle 1, `rise` at cycle 2 → `drop`=1 cycle 3. Pending target 1 equals `level`, so at cycle 5 `level` stays 1, `pending`=0, `busy` stays 0.
5. **Toggles and no-ops.** Idle at `level`=0: `double` → `level`=1; after the hold, `rise`+`fall` in the same cycle → `level`=0. `fall` while `level`=0 and idle → no change, `busy` stays 0.
6. **Pure converter and reset mid-hold.**
   - `MIN_HOLD`=1: `rise`, `fall`, `rise` in cycles 0, 1, 2 → `level`=1, 0, 1 in cycles 1, 2, 3; `busy` never asserts.
   - `MIN_HOLD`=4: `rst` pulsed at cycle 2 with an event pending → cycle 3 shows `level`=0, `busy`=0, `pending`=0.

Source files
------------

// File: rtl/pulse2level.sv
// Rebuilds a held level from rise/fall/toggle pulses, holding each new level for
// at least MIN_HOLD cycles; one event can wait during the hold, and drop pulses when it is lost.
module pulse2level #(
  parameter int   MIN_HOLD   = 4,
  parameter int   CNT_W      = 8,
  parameter logic INIT_LEVEL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic rise_i,
  input  logic fall_i,
  input  logic double_i,
  output logic level_o,
  output logic busy_o,
  output logic pending_o,
  output logic drop_o
);

  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(MIN_HOLD - 1);

  logic             level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pend_q, pend_d;
  logic             ptgt_q, ptgt_d;
  logic             drop_q, drop_d;

  logic base, evt, tgt, busy, applied;

  // Toggles are relative to the queued target, so a toggle on top of a queued event acts on that event.
  assign base = pend_q ? ptgt_q : level_q;
  assign evt  = rise_i | fall_i | double_i;
  assign tgt  = (double_i | (rise_i & fall_i)) ? ~base : rise_i;
  assign busy = (cnt_q != '0);

  assign applied = evt ? tgt : ptgt_q;

  always_comb begin
    level_d = level_q;
    cnt_d   = busy ? cnt_q - 1'b1 : cnt_q;
    pend_d  = pend_q;
    ptgt_d  = ptgt_q;
    drop_d  = 1'b0;
    if (busy) begin
      if (evt) begin
        ptgt_d = tgt;
        pend_d = 1'b1;
        drop_d = pend_q;
      end
    end else if (pend_q) begin
      pend_d = 1'b0;
      drop_d = evt;
      if (applied != level_q) begin
        level_d = applied;
        cnt_d   = HOLD_LOAD;
      end
    end else if (evt && (tgt != level_q)) begin
      level_d = tgt;
      cnt_d   = HOLD_LOAD;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      level_q <= INIT_LEVEL;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      ptgt_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      level_q <= level_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      ptgt_q  <= ptgt_d;
      drop_q  <= drop_d;
    end
  end

  assign level_o   = level_q;
  assign busy_o    = busy;
  assign pending_o = pend_q;
  assign drop_o    = drop_q;

endmodule
